// File: rtl/sram_req_arbiter.sv
// Purpose : shares one like-SRAM bus port between the inst_sram (IF) and data_sram (EXE) request sides.
// Latency : zero added cycles; request, accept and response paths are combinational through the arbiter.
// Backpr. : bus_req is held low while MAX_OUTSTANDING responses are pending; a source sees addr_ok only when granted.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   inst_sram_*  (in: req/wr/size/wstrb/addr/wdata, out: addr_ok/data_ok/rdata)  IF-stage request side
//   data_sram_*  (in: req/wr/size/wstrb/addr/wdata, out: addr_ok/data_ok/rdata)  EXE-stage request side
//   bus_*        (out: req/wr/size/wstrb/addr/wdata, in: addr_ok/data_ok/rdata)  shared bus toward the AXI bridge
//   err_stray_data_ok               sticky flag: a bus response arrived with no transaction outstanding
//
// Arbitration: data wins over inst, except that after STARVE_LIMIT consecutive data
// grants with inst waiting, inst is given one grant. Once a source is granted but
// not yet accepted, the grant is locked to it until accept or until it drops req.
// Each accepted request pushes its source tag (0=inst, 1=data) into an in-order FIFO;
// the FIFO head steers each bus response back to the requesting side.

module sram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,

  output logic        err_stray_data_ok
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_starve_cnt;
  logic            r_err_stray;

  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_fifo_head;
  logic            w_starved;
  logic            w_gnt_i;
  logic            w_gnt_d;
  logic            w_push;
  logic            w_pop;
  logic            w_hs_i;
  logic            w_hs_d;

  assign w_starved = (r_starve_cnt >= SW'(STARVE_LIMIT));

  // Grant decode. Grants are already qualified by the owner's req and by FIFO
  // space, so a grant is exactly "bus_req is driven for this source".
  always_comb begin
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_sram_req && (!inst_sram_req || !w_starved)) begin
          w_gnt_d = 1'b1;
        end else if (inst_sram_req) begin
          w_gnt_i = 1'b1;
        end
      end
      ST_LOCK_I: w_gnt_i = inst_sram_req;
      ST_LOCK_D: w_gnt_d = data_sram_req;
      default: ;
    endcase
    if (w_fifo_full) begin
      w_gnt_i = 1'b0;
      w_gnt_d = 1'b0;
    end
  end

  assign bus_req = w_gnt_i | w_gnt_d;

  // Request field mux; zero when nobody is granted so idle bus fields are quiet.
  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_wstrb = 4'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    if (w_gnt_d) begin
      bus_wr    = data_sram_wr;
      bus_size  = data_sram_size;
      bus_wstrb = data_sram_wstrb;
      bus_addr  = data_sram_addr;
      bus_wdata = data_sram_wdata;
    end else if (w_gnt_i) begin
      bus_wr    = inst_sram_wr;
      bus_size  = inst_sram_size;
      bus_wstrb = inst_sram_wstrb;
      bus_addr  = inst_sram_addr;
      bus_wdata = inst_sram_wdata;
    end
  end

  assign w_hs_i = w_gnt_i & bus_addr_ok;
  assign w_hs_d = w_gnt_d & bus_addr_ok;
  assign w_push = bus_req & bus_addr_ok;

  assign inst_sram_addr_ok = w_hs_i;
  assign data_sram_addr_ok = w_hs_d;

  // Response routing: a response with nothing outstanding is dropped and flagged.
  assign w_pop             = bus_data_ok & ~w_fifo_empty;
  assign inst_sram_data_ok = w_pop & ~w_fifo_head;
  assign data_sram_data_ok = w_pop &  w_fifo_head;
  assign inst_sram_rdata   = bus_rdata;
  assign data_sram_rdata   = bus_rdata;

  assign err_stray_data_ok = r_err_stray;

  // Grant FSM. A granted-but-not-accepted request locks the grant so the bus
  // never sees the request fields change under an unaccepted req. While locked
  // and the FIFO is full, the lock is held; dropping req releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_d && !bus_addr_ok) begin
            r_state <= ST_LOCK_D;
          end else if (w_gnt_i && !bus_addr_ok) begin
            r_state <= ST_LOCK_I;
          end
        end
        ST_LOCK_I: begin
          if (!inst_sram_req || w_hs_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOCK_D: begin
          if (!data_sram_req || w_hs_d) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Counts data accepts that overtook a waiting inst request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!inst_sram_req || w_hs_i) begin
      r_starve_cnt <= '0;
    end else if (w_hs_d && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_stray <= 1'b0;
    end else if (bus_data_ok && w_fifo_empty) begin
      r_err_stray <= 1'b1;
    end
  end

  sram_req_arbiter_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push_vld (w_push),
    .i_push_dat (w_gnt_d),
    .i_pop_vld  (w_pop),
    .o_head_dat (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

endmodule

// Purpose : small synchronous FIFO holding per-transaction tags in acceptance order.
// Latency : pushed entry visible at head the cycle after push; head is read combinationally.
// Backpr. : o_full / o_empty reflect registered occupancy; push when full and pop when empty are ignored.
//
// Ports
//   clk, reset              clock, synchronous active-high reset (empties the FIFO)
//   i_push_vld, i_push_dat  write side
//   i_pop_vld               consume the head entry
//   o_head_dat              oldest entry
//   o_full, o_empty         occupancy status
module sram_req_arbiter_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop_vld,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_do_push = i_push_vld & ~o_full;
  assign w_do_pop  = i_pop_vld  & ~o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        err_stray_data_ok;

  int total;
  int bad;

  localparam logic [31:0] D_ADDR  = 32'h1000_0010;
  localparam logic [31:0] D_WDATA = 32'hDEAD_BEEF;
  localparam logic [31:0] I_WDATA = 32'hAAAA_5555;

  sram_req_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .err_stray_data_ok(err_stray_data_ok)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven there and
  // outputs are checked 1ns later, well before the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [11:0] pat;
    total = 0;
    bad   = 0;

    reset           = 1'b1;
    inst_sram_req   = 1'b0;
    inst_sram_wr    = 1'b0;
    inst_sram_size  = 2'd2;
    inst_sram_wstrb = 4'h0;
    inst_sram_addr  = 32'hBFC0_0000;
    inst_sram_wdata = I_WDATA;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b1;
    data_sram_size  = 2'd2;
    data_sram_wstrb = 4'hF;
    data_sram_addr  = D_ADDR;
    data_sram_wdata = D_WDATA;
    bus_addr_ok     = 1'b0;
    bus_data_ok     = 1'b0;
    bus_rdata       = 32'h0;
    pat             = 12'b0110_1001_1101;

    // ---- reset state
    tick(); tick();
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_i_aok", inst_sram_addr_ok, 0);
    check("rst_d_aok", data_sram_addr_ok, 0);
    check("rst_i_dok", inst_sram_data_ok, 0);
    check("rst_d_dok", data_sram_data_ok, 0);
    check("rst_err", err_stray_data_ok, 0);
    reset = 1'b0;
    tick();

    // ---- 1: single inst read, accepted at once, data next cycle
    inst_sram_req = 1'b1; bus_addr_ok = 1'b1;
    #1;
    check("t1_bus_req", bus_req, 1);
    check("t1_bus_addr", bus_addr, 32'hBFC0_0000);
    check("t1_bus_wr", bus_wr, 0);
    check("t1_i_aok", inst_sram_addr_ok, 1);
    check("t1_d_aok", data_sram_addr_ok, 0);
    tick();
    inst_sram_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2408_0001;
    #1;
    check("t1_i_dok", inst_sram_data_ok, 1);
    check("t1_i_rdata", inst_sram_rdata, 32'h2408_0001);
    check("t1_d_dok", data_sram_data_ok, 0);
    check("t1_bus_req_off", bus_req, 0);
    tick();
    bus_data_ok = 1'b0;

    // ---- 2: both request, data first, then inst; responses D then I
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0004;
    data_sram_req = 1'b1; bus_addr_ok = 1'b1;
    #1;
    check("t2_d_aok", data_sram_addr_ok, 1);
    check("t2_i_aok_0", inst_sram_addr_ok, 0);
    check("t2_addr_d", bus_addr, D_ADDR);
    check("t2_wr_d", bus_wr, 1);
    check("t2_wdata_d", bus_wdata, D_WDATA);
    check("t2_wstrb_d", bus_wstrb, 32'hF);
    tick();
    data_sram_req = 1'b0;
    #1;
    check("t2_i_aok", inst_sram_addr_ok, 1);
    check("t2_addr_i", bus_addr, 32'hBFC0_0004);
    check("t2_wdata_i", bus_wdata, I_WDATA);
    tick();
    inst_sram_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
    #1;
    check("t2_resp1_d", data_sram_data_ok, 1);
    check("t2_resp1_i", inst_sram_data_ok, 0);
    check("t2_d_rdata", data_sram_rdata, 32'h1111_1111);
    tick();
    bus_rdata = 32'h2222_2222;
    #1;
    check("t2_resp2_i", inst_sram_data_ok, 1);
    check("t2_resp2_d", data_sram_data_ok, 0);
    tick();
    bus_data_ok = 1'b0;

    // ---- 3: starvation relief after 8 data accepts
    inst_sram_req = 1'b1; data_sram_req = 1'b1; bus_addr_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus_data_ok = (k >= 1);
      bus_rdata   = 32'h3000_0000 + k;
      #1;
      check("t3_i_aok", inst_sram_addr_ok, k == 8);
      check("t3_d_aok", data_sram_addr_ok, k != 8);
      if (k >= 1) begin
        check("t3_i_dok", inst_sram_data_ok, k == 9);
        check("t3_d_dok", data_sram_data_ok, k != 9);
      end
      tick();
    end
    inst_sram_req = 1'b0; data_sram_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    #1;
    check("t3_drain_d", data_sram_data_ok, 1);
    tick();
    bus_data_ok = 1'b0;

    // ---- 4: FIFO full masking, pop+push same cycle
    data_sram_req = 1'b1; bus_addr_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t4_fill_req", bus_req, 1);
      tick();
    end
    #1;
    check("t4_full_req", bus_req, 0);
    check("t4_full_aok", data_sram_addr_ok, 0);
    check("t4_full_addr", bus_addr, 0);
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h4400_0000;
    #1;
    check("t4_pop_req", bus_req, 0);
    check("t4_pop_dok", data_sram_data_ok, 1);
    tick();
    bus_addr_ok = 1'b1;
    #1;
    check("t4_pp_req", bus_req, 1);
    check("t4_pp_aok", data_sram_addr_ok, 1);
    check("t4_pp_dok", data_sram_data_ok, 1);
    tick();
    bus_data_ok = 1'b0;
    #1;
    check("t4_last_req", bus_req, 1);
    tick();
    #1;
    check("t4_refull_req", bus_req, 0);
    tick();
    data_sram_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t4_drain_d", data_sram_data_ok, 1);
      check("t4_drain_i", inst_sram_data_ok, 0);
      tick();
    end
    bus_data_ok = 1'b0;
    #1;
    check("t4_err", err_stray_data_ok, 0);

    // ---- 4b: 12 mixed-source txns, two outstanding, pointers wrap
    for (int j = 0; j < 14; j++) begin
      if (j < 12) begin
        inst_sram_req = !pat[j]; data_sram_req = pat[j]; bus_addr_ok = 1'b1;
      end else begin
        inst_sram_req = 1'b0; data_sram_req = 1'b0; bus_addr_ok = 1'b0;
      end
      bus_data_ok = (j >= 2);
      #1;
      if (j < 12) begin
        check("t4w_i_aok", inst_sram_addr_ok, !pat[j]);
        check("t4w_d_aok", data_sram_addr_ok, pat[j]);
      end
      if (j >= 2) begin
        check("t4w_i_dok", inst_sram_data_ok, !pat[j-2]);
        check("t4w_d_dok", data_sram_data_ok, pat[j-2]);
      end
      tick();
    end
    bus_data_ok = 1'b0;

    // ---- 5: locked data request withdrawn, then inst; inst lock holds off data
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0008; data_sram_req = 1'b1; bus_addr_ok = 1'b0;
    #1;
    check("t5_req_d", bus_req, 1);
    check("t5_addr_d", bus_addr, D_ADDR);
    tick();
    #1;
    check("t5_lock_addr", bus_addr, D_ADDR);
    check("t5_lock_i_aok", inst_sram_addr_ok, 0);
    tick();
    data_sram_req = 1'b0;
    #1;
    check("t5_drop_req", bus_req, 0);
    tick();
    bus_addr_ok = 1'b1;
    #1;
    check("t5_i_aok", inst_sram_addr_ok, 1);
    check("t5_i_addr", bus_addr, 32'hBFC0_0008);
    tick();
    bus_addr_ok = 1'b0;
    #1;
    check("t5_li_addr", bus_addr, 32'hBFC0_0008);
    tick();
    data_sram_req = 1'b1;
    #1;
    check("t5_li_hold", bus_addr, 32'hBFC0_0008);
    check("t5_li_wr", bus_wr, 0);
    tick();
    bus_addr_ok = 1'b1;
    #1;
    check("t5_li_aok", inst_sram_addr_ok, 1);
    check("t5_li_daok", data_sram_addr_ok, 0);
    tick();
    inst_sram_req = 1'b0; data_sram_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t5_resp_i", inst_sram_data_ok, 1);
      check("t5_resp_d", data_sram_data_ok, 0);
      tick();
    end
    bus_data_ok = 1'b0;
    #1;
    check("t5_err", err_stray_data_ok, 0);

    // ---- 6: reset with 2 outstanding; late responses are stray
    data_sram_req = 1'b1; bus_addr_ok = 1'b1;
    #1;
    check("t6_aok0", data_sram_addr_ok, 1);
    tick();
    #1;
    check("t6_aok1", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 1'b0; bus_addr_ok = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; bus_data_ok = 1'b1;
    #1;
    check("t6_i_dok", inst_sram_data_ok, 0);
    check("t6_d_dok", data_sram_data_ok, 0);
    check("t6_err_pre", err_stray_data_ok, 0);
    tick();
    bus_data_ok = 1'b0;
    #1;
    check("t6_err_set", err_stray_data_ok, 1);
    tick(); tick();
    check("t6_err_held", err_stray_data_ok, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_err_clr", err_stray_data_ok, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
